// File: rtl/queue_fifo_pkg.sv
// Shared helpers for the parametrised FWFT queue: pointer-width derivation and
// the occupancy-from-pointers calculation.
package queue_pkg;

    function automatic int aw_of(input int depth);
        return $clog2(depth);
    endfunction

    // Occupancy implied by a write/read pointer pair that wraps modulo 2*depth.
    function automatic int unsigned ptr_diff(input int unsigned wptr,
                                             input int unsigned rptr,
                                             input int unsigned depth);
        return (wptr - rptr) % (2 * depth);
    endfunction

endpackage

// File: rtl/queue_fifo_if.sv
// Handshake/status bundle between a producer/consumer and queue_fifo.
// high_water is present only when QUEUE_FIFO_WATERMARK_EN is defined.
interface queue_fifo_if
    import queue_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
);
    localparam int AW = aw_of(DEPTH);

    logic             push;
    logic             pop;
    logic             clear_err;
    logic [WIDTH-1:0] din;
    logic [WIDTH-1:0] dout;
    logic             full;
    logic             empty;
    logic             almost_full;
    logic             almost_empty;
    logic [AW:0]      count;
    logic             overflow;
    logic             underflow;
`ifdef QUEUE_FIFO_WATERMARK_EN
    logic [AW:0]      high_water;

    modport master (output push, pop, clear_err, din,
                    input  dout, full, empty, almost_full, almost_empty,
                           count, overflow, underflow, high_water);
    modport slave  (input  push, pop, clear_err, din,
                    output dout, full, empty, almost_full, almost_empty,
                           count, overflow, underflow, high_water);
`else
    modport master (output push, pop, clear_err, din,
                    input  dout, full, empty, almost_full, almost_empty,
                           count, overflow, underflow);
    modport slave  (input  push, pop, clear_err, din,
                    output dout, full, empty, almost_full, almost_empty,
                           count, overflow, underflow);
`endif
endinterface

// File: rtl/queue_fifo_ptr.sv
// Pointer, occupancy, status-flag and sticky-error control for queue_fifo.
// Optional peak-occupancy tracking under QUEUE_FIFO_WATERMARK_EN.
module queue_fifo_ptr
    import queue_pkg::*;
#(
    parameter int DEPTH    = 8,
    parameter int AF_LEVEL = DEPTH - 1,
    parameter int AE_LEVEL = 1,
    localparam int AW      = aw_of(DEPTH)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          push_i,
    input  logic          pop_i,
    input  logic          clear_err_i,
    output logic          wr_en_o,
    output logic [AW-1:0] widx_o,
    output logic [AW-1:0] ridx_o,
    output logic [AW:0]   count_o,
    output logic          full_o,
    output logic          empty_o,
    output logic          almost_full_o,
    output logic          almost_empty_o,
    output logic          overflow_o,
    output logic          underflow_o
`ifdef QUEUE_FIFO_WATERMARK_EN
   ,output logic [AW:0]   high_water_o
`endif
);
    localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);
    localparam logic [AW:0] AF_C    = (AW+1)'(AF_LEVEL);
    localparam logic [AW:0] AE_C    = (AW+1)'(AE_LEVEL);
    localparam logic [AW:0] ONE     = {{AW{1'b0}}, 1'b1};

    logic [AW:0] wptr_q, wptr_d, rptr_q, rptr_d, count_q, count_d;
    logic        ovf_q, ovf_d, unf_q, unf_d;
    logic        push_ok, pop_ok;

    // All status decodes come from registered count only: no push/pop paths.
    assign full_o         = (count_q == DEPTH_C);
    assign empty_o        = (count_q == '0);
    assign almost_full_o  = (count_q >= AF_C);
    assign almost_empty_o = (count_q <= AE_C);
    assign count_o        = count_q;
    assign overflow_o     = ovf_q;
    assign underflow_o    = unf_q;
    assign widx_o         = wptr_q[AW-1:0];
    assign ridx_o         = rptr_q[AW-1:0];

    // A pop frees the slot the write lands in, so push is legal when full.
    assign push_ok = push_i & (~full_o | pop_i);
    assign pop_ok  = pop_i & ~empty_o;
    assign wr_en_o = push_ok;

    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        ovf_d   = ovf_q;
        unf_d   = unf_q;
        if (push_ok) wptr_d = wptr_q + ONE;
        if (pop_ok)  rptr_d = rptr_q + ONE;
        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + ONE;
            2'b01:   count_d = count_q - ONE;
            default: count_d = count_q;
        endcase
        if (clear_err_i) begin
            ovf_d = 1'b0;
            unf_d = 1'b0;
        end
        if (push_i & full_o & ~pop_i) ovf_d = 1'b1;
        if (pop_i & empty_o)          unf_d = 1'b1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
        end
    end

`ifdef QUEUE_FIFO_WATERMARK_EN
    logic [AW:0] hw_q, hw_d;

    always_comb begin
        hw_d = hw_q;
        if (clear_err_i)          hw_d = count_q;
        else if (count_d > hw_q)  hw_d = count_d;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) hw_q <= '0;
        else       hw_q <= hw_d;
    end

    assign high_water_o = hw_q;
`endif

endmodule

// File: rtl/queue_fifo.sv
// Parametrised first-word-fall-through FIFO: register-array storage with a
// combinational head read. Optional high_water output under QUEUE_FIFO_WATERMARK_EN.
module queue_fifo
    import queue_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter int DEPTH    = 8,
    parameter int AF_LEVEL = DEPTH - 1,
    parameter int AE_LEVEL = 1,
    localparam int AW      = aw_of(DEPTH)
) (
    input  logic         clk,
    input  logic         reset,
    queue_fifo_if.slave  q
);
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             wr_en;
    logic [AW-1:0]    widx, ridx;

    queue_fifo_ptr #(
        .DEPTH    (DEPTH),
        .AF_LEVEL (AF_LEVEL),
        .AE_LEVEL (AE_LEVEL)
    ) u_ptr (
        .clk            (clk),
        .reset          (reset),
        .push_i         (q.push),
        .pop_i          (q.pop),
        .clear_err_i    (q.clear_err),
        .wr_en_o        (wr_en),
        .widx_o         (widx),
        .ridx_o         (ridx),
        .count_o        (q.count),
        .full_o         (q.full),
        .empty_o        (q.empty),
        .almost_full_o  (q.almost_full),
        .almost_empty_o (q.almost_empty),
        .overflow_o     (q.overflow),
        .underflow_o    (q.underflow)
`ifdef QUEUE_FIFO_WATERMARK_EN
       ,.high_water_o   (q.high_water)
`endif
    );

    // Storage is deliberately not reset; dout is stale while empty.
    always_ff @(posedge clk) begin
        if (wr_en) mem_q[widx] <= q.din;
    end

    assign q.dout = mem_q[ridx];

endmodule

// File: tb/tb_queue_fifo.sv
// Scoreboard bench for queue_fifo (WIDTH=8, DEPTH=8, AF_LEVEL=6, AE_LEVEL=1).
module tb_queue_fifo;
    import queue_pkg::*;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    queue_fifo_if #(.WIDTH(8), .DEPTH(8)) ifc ();

    queue_fifo #(.WIDTH(8), .DEPTH(8), .AF_LEVEL(6), .AE_LEVEL(1)) dut (
        .clk   (clk),
        .reset (reset),
        .q     (ifc)
    );

    int checks = 0;
    int errors = 0;

    logic [7:0]  sb[$];
    int unsigned mw = 0, mr = 0, mhw = 0;
    logic        movf = 1'b0, munf = 1'b0;

    function automatic int unsigned mcount();
        return ptr_diff(mw, mr, 8);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: outputs sampled mid-cycle against the model state.
    always @(negedge clk) begin : monitor
        int unsigned c;
        c = mcount();
        chk("count",        32'(ifc.count),     c);
        chk("empty",        32'(ifc.empty),     32'(c == 0));
        chk("full",         32'(ifc.full),      32'(c == 8));
        chk("almost_full",  32'(ifc.almost_full),  32'(c >= 6));
        chk("almost_empty", 32'(ifc.almost_empty), 32'(c <= 1));
        chk("overflow",     32'(ifc.overflow),  32'(movf));
        chk("underflow",    32'(ifc.underflow), 32'(munf));
`ifdef QUEUE_FIFO_WATERMARK_EN
        chk("high_water",   32'(ifc.high_water), mhw);
`endif
        if (!reset && ifc.pop && c > 0) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL dout: scoreboard empty on pop (t=%0t)", $time);
            end else begin
                chk("dout", 32'(ifc.dout), 32'(sb.pop_front()));
            end
        end
    end

    task automatic step(input logic p, input logic o, input logic [7:0] d, input logic clr = 1'b0);
        int unsigned c, nc;
        logic pok, wok;
        ifc.push = p; ifc.pop = o; ifc.din = d; ifc.clear_err = clr;
        @(posedge clk);
        c   = mcount();
        pok = o && (c > 0);
        wok = p && ((c < 8) || o);
        nc  = c + (wok ? 1 : 0) - (pok ? 1 : 0);
        if (p && c == 8 && !o) movf = 1'b1; else if (clr) movf = 1'b0;
        if (o && c == 0)       munf = 1'b1; else if (clr) munf = 1'b0;
        if (clr) mhw = c; else if (nc > mhw) mhw = nc;
        if (wok) begin sb.push_back(d); mw = (mw + 1) % 16; end
        if (pok) mr = (mr + 1) % 16;
        #1;
    endtask

    task automatic model_reset();
        mw = 0; mr = 0; mhw = 0; movf = 1'b0; munf = 1'b0;
        sb.delete();
    endtask

    int ops[20] = '{1,1,1,1,1,2,2,3,1,3,2,2,2,1,1,2,2,2,1,2};

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin : stimulus
        reset = 1'b1;
        ifc.push = 1'b0; ifc.pop = 1'b0; ifc.din = '0; ifc.clear_err = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset = 1'b0;

        // 1: async reset mid-cycle with 3 entries held
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 8'hE1 + 8'(i));
        #1;
        ifc.push = 1'b0; ifc.pop = 1'b0;
        reset = 1'b1;
        model_reset();
        #1;
        chk("rst_async_count", 32'(ifc.count), 0);
        chk("rst_async_empty", 32'(ifc.empty), 1);
        chk("rst_async_full",  32'(ifc.full),  0);
        chk("rst_async_ae",    32'(ifc.almost_empty), 1);
        chk("rst_async_ovf",   32'(ifc.overflow),  0);
        @(posedge clk); #1;
        reset = 1'b0;

        // 2: fill 0x01..0x08 then drain
        for (int i = 1; i <= 8; i++) step(1'b1, 1'b0, 8'(i));
        for (int i = 0; i < 8; i++)  step(1'b0, 1'b1, 8'h00);

        // 3: overflow on a full FIFO, then clear_err
        for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 8'hA0 + 8'(i));
        step(1'b1, 1'b0, 8'hAA);
        chk("t3_overflow", 32'(ifc.overflow), 1);
        step(1'b0, 1'b0, 8'h00, 1'b1);
        chk("t3_cleared", 32'(ifc.overflow), 0);

        // 4: push+pop while full; 0x55 comes out 8th
        step(1'b1, 1'b1, 8'h55);
        chk("t4_count", 32'(ifc.count), 8);
        for (int i = 0; i < 8; i++) step(1'b0, 1'b1, 8'h00);

        // 5: push+pop while empty
        step(1'b1, 1'b1, 8'h3C);
        chk("t5_underflow", 32'(ifc.underflow), 1);
        chk("t5_dout",      32'(ifc.dout), 32'h3C);
        step(1'b0, 1'b1, 8'h00);
        step(1'b0, 1'b0, 8'h00, 1'b1);

        // 6: interleaved traffic across the pointer wrap
        for (int i = 0; i < 20; i++)
            step(ops[i][0], ops[i][1], 8'h10 + 8'(i));
`ifdef QUEUE_FIFO_WATERMARK_EN
        chk("t6_high_water", 32'(ifc.high_water), 5);
`endif
        step(1'b0, 1'b0, 8'h00);
        step(1'b0, 1'b0, 8'h00);
        chk("sb_drained", 32'(sb.size()), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
